// File: rtl/aes_io_ctrl_if.sv
// aes_io_ctrl_if: host/core bus bundle for the AES I/O controller.
//   Host side : din, cmd -> ; interface_ready, engine_done, cmd_err, dout, dout_valid <-
//   Core side : block_o, key_o, start_o <- ; core_done_i, result_i ->
//   modport slave  : the controller's view.
//   modport master : the host plus core-stub view that drives the controller.
interface aes_io_ctrl_if #(
  parameter int DIN_W    = 8,
  parameter int KEY_BITS = 128
);
  logic [DIN_W-1:0]    din;
  logic [1:0]          cmd;
  logic                interface_ready;
  logic                engine_done;
  logic                cmd_err;
  logic [127:0]        block_o;
  logic [KEY_BITS-1:0] key_o;
  logic                start_o;
  logic                core_done_i;
  logic [127:0]        result_i;
  logic [DIN_W-1:0]    dout;
  logic                dout_valid;

  modport slave (
    input  din, cmd, core_done_i, result_i,
    output interface_ready, engine_done, cmd_err, block_o, key_o, start_o, dout, dout_valid
  );

  modport master (
    output din, cmd, core_done_i, result_i,
    input  interface_ready, engine_done, cmd_err, block_o, key_o, start_o, dout, dout_valid
  );
endinterface

// File: rtl/aes_io_ctrl.sv
// aes_io_ctrl: host-side command front end for the AES round core.
//   clk, rst_ : single rising-edge clock, synchronous active-low reset.
//   bus       : aes_io_ctrl_if.slave
//     din/cmd             beat stream; cmd 00 idle, 01 plaintext, 10 key, 11 start
//     interface_ready     plaintext and key complete, controller idle
//     engine_done/cmd_err one-cycle pulses (result captured / command rejected)
//     block_o/key_o       operands to the core, mirror the load registers
//     start_o             one-cycle core launch
//     core_done_i/result_i core completion and ciphertext
//     dout/dout_valid     ciphertext, MSB beat first, 128/DIN_W cycles
module aes_io_ctrl #(
  parameter int DIN_W    = 8,
  parameter int KEY_BITS = 128
) (
  input logic         clk,
  input logic         rst_,
  aes_io_ctrl_if.slave bus
);
  localparam int BP  = 128 / DIN_W;
  localparam int BK  = KEY_BITS / DIN_W;
  localparam int PCW = $clog2(BP + 1);
  localparam int KCW = $clog2(BK + 1);
  localparam int OCW = $clog2(BP);

  localparam logic [1:0] CMD_PT  = 2'b01;
  localparam logic [1:0] CMD_KEY = 2'b10;
  localparam logic [1:0] CMD_GO  = 2'b11;

  if ((DIN_W != 8 && DIN_W != 16 && DIN_W != 32) ||
      (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) ||
      (128 % DIN_W) != 0 || (KEY_BITS % DIN_W) != 0) begin : g_param_err
    $error("aes_io_ctrl: unsupported DIN_W/KEY_BITS combination");
  end

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_OUT} state_t;

  state_t              state, state_nxt;
  logic [127:0]        pt, out_sr;
  logic [KEY_BITS-1:0] key;
  logic [PCW-1:0]      pt_cnt;
  logic [KCW-1:0]      key_cnt;
  logic [OCW-1:0]      out_cnt;
  logic                pt_full, key_full;
  logic [1:0]          cmd_q;
  logic                engine_done_q, cmd_err_q;

  logic idle, ready, go, err_nxt, capture, out_last;

  assign idle     = (state == S_IDLE);
  assign ready    = idle && pt_full && key_full;
  assign go       = ready && (bus.cmd == CMD_GO);
  assign capture  = (state == S_WAIT) && bus.core_done_i;
  assign out_last = (out_cnt == OCW'(BP - 1));
  // In IDLE only an unready start is an error; when busy any load is an error
  // while a repeated start is dropped silently.
  assign err_nxt  = idle ? (bus.cmd == CMD_GO && !ready)
                         : (bus.cmd == CMD_PT || bus.cmd == CMD_KEY);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (go) state_nxt = S_START;
      S_START: state_nxt = S_WAIT;          // core_done_i deliberately ignored here
      S_WAIT:  if (bus.core_done_i) state_nxt = S_OUT;
      S_OUT:   if (out_last) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Load registers, result shifter and registered pulses
  always_ff @(posedge clk) begin
    if (!rst_) begin
      pt            <= '0;
      key           <= '0;
      out_sr        <= '0;
      pt_cnt        <= '0;
      key_cnt       <= '0;
      out_cnt       <= '0;
      pt_full       <= 1'b0;
      key_full      <= 1'b0;
      cmd_q         <= '0;
      engine_done_q <= 1'b0;
      cmd_err_q     <= 1'b0;
    end else begin
      cmd_q         <= bus.cmd;
      cmd_err_q     <= err_nxt;
      engine_done_q <= capture;

      // A fresh entry into a load command restarts that field from scratch.
      if (idle && bus.cmd == CMD_PT) begin
        if (cmd_q != CMD_PT) begin
          pt      <= {{(128-DIN_W){1'b0}}, bus.din};
          pt_cnt  <= PCW'(1);
          pt_full <= 1'b0;
        end else if (!pt_full) begin
          pt      <= {pt[127-DIN_W:0], bus.din};
          pt_cnt  <= pt_cnt + 1'b1;
          pt_full <= (pt_cnt == PCW'(BP - 1));
        end
      end

      if (idle && bus.cmd == CMD_KEY) begin
        if (cmd_q != CMD_KEY) begin
          key      <= {{(KEY_BITS-DIN_W){1'b0}}, bus.din};
          key_cnt  <= KCW'(1);
          key_full <= 1'b0;
        end else if (!key_full) begin
          key      <= {key[KEY_BITS-1-DIN_W:0], bus.din};
          key_cnt  <= key_cnt + 1'b1;
          key_full <= (key_cnt == KCW'(BK - 1));
        end
      end

      // Key is kept across blocks; only the plaintext must be reloaded.
      if (go) pt_full <= 1'b0;

      if (capture) begin
        out_sr  <= bus.result_i;
        out_cnt <= '0;
      end else if (state == S_OUT) begin
        out_sr  <= out_sr << DIN_W;
        out_cnt <= out_cnt + 1'b1;
      end
    end
  end

  // Outputs
  always_comb begin
    bus.interface_ready = ready;
    bus.start_o         = (state == S_START);
    bus.dout_valid      = (state == S_OUT);
    bus.dout            = out_sr[127 -: DIN_W];
    bus.engine_done     = engine_done_q;
    bus.cmd_err         = cmd_err_q;
    bus.block_o         = pt;
    bus.key_o           = key;
  end
endmodule

// File: tb/tb_aes_io_ctrl.sv
// tb_aes_io_ctrl: randomized self-checking bench for aes_io_ctrl.
//   dut_a: DIN_W=8,  KEY_BITS=128 (main scenarios)
//   dut_b: DIN_W=32, KEY_BITS=256 (wide configuration)
// The model tracks which operands are complete and their values as whole
// 128-bit numbers; expected output beats are the ciphertext read MSB first.
module tb_aes_io_ctrl;
  logic clk = 1'b0;
  logic rst_ = 1'b0;
  always #5 clk = ~clk;

  aes_io_ctrl_if #(.DIN_W(8),  .KEY_BITS(128)) ba();
  aes_io_ctrl_if #(.DIN_W(32), .KEY_BITS(256)) bb();

  aes_io_ctrl #(.DIN_W(8),  .KEY_BITS(128)) dut_a (.clk(clk), .rst_(rst_), .bus(ba.slave));
  aes_io_ctrl #(.DIN_W(32), .KEY_BITS(256)) dut_b (.clk(clk), .rst_(rst_), .bus(bb.slave));

  int vecs = 0;
  int miss = 0;

  // Reference model for dut_a
  logic [127:0] m_pt, m_key;
  bit           m_ptf, m_keyf;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Drives nb beats of v (MSB first) then 'extra' junk beats under one command.
  task automatic load_a(input bit is_key, input logic [127:0] v, input int nb, input int extra);
    for (int i = 0; i < nb + extra; i++) begin
      ba.cmd = is_key ? 2'b10 : 2'b01;
      ba.din = (i < nb) ? 8'(v >> (120 - 8 * i)) : 8'($urandom);
      step();
    end
    ba.cmd = 2'b00;
    if (is_key) begin m_key = v >> (128 - 8 * nb); m_keyf = (nb == 16); end
    else        begin m_pt  = v >> (128 - 8 * nb); m_ptf  = (nb == 16); end
    vecs++;
    if (ba.interface_ready !== (m_ptf && m_keyf)) begin
      miss++; $display("FAIL load_ready got %b exp %b", ba.interface_ready, m_ptf && m_keyf);
    end
    vecs++;
    if (ba.block_o !== m_pt) begin
      miss++; $display("FAIL load_block got %h exp %h", ba.block_o, m_pt);
    end
    vecs++;
    if (ba.key_o !== m_key) begin
      miss++; $display("FAIL load_key got %h exp %h", ba.key_o, m_key);
    end
  endtask

  // Start a block, stub the core with latency lat, check the output stream.
  // probe: exercise busy rejections and a done pulse during START.
  // abort_at: assert reset right after that output beat (-1 = never).
  task automatic run_a(input logic [127:0] res, input int lat, input bit probe, input int abort_at);
    ba.cmd = 2'b11;
    step();
    ba.cmd = 2'b00;
    m_ptf = 1'b0;
    vecs++;
    if (ba.start_o !== 1'b1 || ba.interface_ready !== 1'b0) begin
      miss++; $display("FAIL start_pulse got start=%b ready=%b exp 1/0", ba.start_o, ba.interface_ready);
    end
    if (probe) begin
      ba.core_done_i = 1'b1;        // seen in START: must be ignored
      ba.result_i = rnd128();
      step();
      ba.core_done_i = 1'b0;
      vecs++;
      if (ba.start_o !== 1'b0 || ba.dout_valid !== 1'b0 || ba.engine_done !== 1'b0) begin
        miss++; $display("FAIL start_done_ignored got start=%b dv=%b done=%b exp 0", ba.start_o, ba.dout_valid, ba.engine_done);
      end
      ba.cmd = 2'b01;
      ba.din = 8'($urandom);
      step();
      ba.cmd = 2'b11;
      vecs++;
      if (ba.cmd_err !== 1'b1 || ba.block_o !== m_pt) begin
        miss++; $display("FAIL busy_load_err got err=%b blk=%h exp 1 %h", ba.cmd_err, ba.block_o, m_pt);
      end
      step();
      ba.cmd = 2'b00;
      vecs++;
      if (ba.cmd_err !== 1'b0 || ba.start_o !== 1'b0) begin
        miss++; $display("FAIL busy_start_silent got err=%b start=%b exp 0/0", ba.cmd_err, ba.start_o);
      end
    end
    for (int i = 0; i < lat; i++) begin
      step();
      vecs++;
      if (ba.start_o !== 1'b0 || ba.dout_valid !== 1'b0 || ba.engine_done !== 1'b0) begin
        miss++; $display("FAIL wait_quiet got start=%b dv=%b done=%b exp 0", ba.start_o, ba.dout_valid, ba.engine_done);
      end
    end
    ba.core_done_i = 1'b1;
    ba.result_i = res;
    step();
    ba.core_done_i = 1'b0;
    ba.result_i = rnd128();
    for (int k = 0; k < 16; k++) begin
      if (k > 0) step();
      vecs++;
      if (ba.dout_valid !== 1'b1 || ba.dout !== 8'(res >> (120 - 8 * k)) ||
          ba.engine_done !== (k == 0)) begin
        miss++; $display("FAIL out_beat%0d got dv=%b d=%h done=%b exp 1 %h %b", k,
                         ba.dout_valid, ba.dout, ba.engine_done, 8'(res >> (120 - 8 * k)), k == 0);
      end
      if (k == abort_at) begin
        rst_ = 1'b0;
        step();
        rst_ = 1'b1;
        m_ptf = 1'b0; m_keyf = 1'b0; m_pt = '0; m_key = '0;
        vecs++;
        if ({ba.dout_valid, ba.interface_ready, ba.engine_done, ba.cmd_err, ba.start_o,
             ba.dout, ba.block_o, ba.key_o} !== '0) begin
          miss++; $display("FAIL abort_clear got dv=%b rdy=%b dout=%h blk=%h key=%h exp 0",
                           ba.dout_valid, ba.interface_ready, ba.dout, ba.block_o, ba.key_o);
        end
        return;
      end
    end
    step();
    vecs++;
    if (ba.dout_valid !== 1'b0 || ba.engine_done !== 1'b0 || ba.interface_ready !== 1'b0) begin
      miss++; $display("FAIL out_end got dv=%b done=%b rdy=%b exp 0", ba.dout_valid, ba.engine_done, ba.interface_ready);
    end
    vecs++;
    if (ba.block_o !== m_pt || ba.key_o !== m_key) begin
      miss++; $display("FAIL operands_stable got %h/%h exp %h/%h", ba.block_o, ba.key_o, m_pt, m_key);
    end
  endtask

  task automatic test_reset();
    ba.din = '0; ba.cmd = '0; ba.core_done_i = 1'b0; ba.result_i = '0;
    bb.din = '0; bb.cmd = '0; bb.core_done_i = 1'b0; bb.result_i = '0;
    rst_ = 1'b0;
    step(); step();
    rst_ = 1'b1;
    m_ptf = 1'b0; m_keyf = 1'b0; m_pt = '0; m_key = '0;
    vecs++;
    if ({ba.dout_valid, ba.interface_ready, ba.engine_done, ba.cmd_err, ba.start_o,
         ba.dout, ba.block_o, ba.key_o} !== '0) begin
      miss++; $display("FAIL reset_a got rdy=%b dv=%b blk=%h key=%h exp 0",
                       ba.interface_ready, ba.dout_valid, ba.block_o, ba.key_o);
    end
    vecs++;
    if ({bb.dout_valid, bb.interface_ready, bb.engine_done, bb.cmd_err, bb.start_o,
         bb.dout, bb.block_o, bb.key_o} !== '0) begin
      miss++; $display("FAIL reset_b got rdy=%b dv=%b blk=%h key=%h exp 0",
                       bb.interface_ready, bb.dout_valid, bb.block_o, bb.key_o);
    end
  endtask

  task automatic test_spec_vector();
    load_a(1'b0, 128'h00041214120412000C00131108231919, 16, 0);
    load_a(1'b1, 128'h2475A2B33475568831E2120013AA5487, 16, 0);
    run_a(128'h0123456789ABCDEF0123456789ABCDEF, 10, 1'b0, -1);
  endtask

  task automatic test_key_retained();
    load_a(1'b0, rnd128(), 16, 0);
    run_a(rnd128(), 4, 1'b1, -1);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 4; n++) begin
      load_a(1'b0, rnd128(), 16, int'($urandom_range(0, 3)));
      run_a(rnd128(), int'($urandom_range(1, 8)), 1'b0, -1);
    end
  endtask

  task automatic test_not_ready();
    test_reset();
    load_a(1'b0, rnd128(), 16, 0);
    load_a(1'b1, rnd128(), 8, 0);
    ba.cmd = 2'b11;
    for (int i = 0; i < 3; i++) begin
      step();
      vecs++;
      if (ba.cmd_err !== 1'b1 || ba.start_o !== 1'b0) begin
        miss++; $display("FAIL not_ready_err%0d got err=%b start=%b exp 1/0", i, ba.cmd_err, ba.start_o);
      end
    end
    ba.cmd = 2'b00;
    step();
    vecs++;
    if (ba.cmd_err !== 1'b0 || ba.start_o !== 1'b0) begin
      miss++; $display("FAIL not_ready_release got err=%b start=%b exp 0/0", ba.cmd_err, ba.start_o);
    end
  endtask

  // Partial plaintext interrupted by a key load must restart from scratch.
  task automatic test_interleave();
    load_a(1'b0, rnd128(), 5, 0);
    load_a(1'b1, rnd128(), 16, 0);
    load_a(1'b0, rnd128(), 16, 2);
    run_a(rnd128(), 2, 1'b0, -1);
  endtask

  task automatic test_reset_mid_out();
    load_a(1'b0, rnd128(), 16, 0);
    load_a(1'b1, rnd128(), 16, 0);
    run_a(rnd128(), 3, 1'b0, 4);
    ba.cmd = 2'b11;
    step();
    ba.cmd = 2'b00;
    vecs++;
    if (ba.cmd_err !== 1'b1 || ba.start_o !== 1'b0) begin
      miss++; $display("FAIL post_abort_start got err=%b start=%b exp 1/0", ba.cmd_err, ba.start_o);
    end
  endtask

  task automatic test_wide();
    logic [127:0] p, r;
    logic [255:0] k;
    p = rnd128(); r = rnd128(); k = {rnd128(), rnd128()};
    for (int i = 0; i < 4; i++) begin
      bb.cmd = 2'b01; bb.din = 32'(p >> (96 - 32 * i)); step();
    end
    for (int i = 0; i < 8; i++) begin
      bb.cmd = 2'b10; bb.din = 32'(k >> (224 - 32 * i)); step();
    end
    bb.cmd = 2'b00;
    vecs++;
    if (bb.interface_ready !== 1'b1 || bb.block_o !== p || bb.key_o !== k) begin
      miss++; $display("FAIL wide_load got rdy=%b blk=%h key=%h exp 1 %h %h", bb.interface_ready, bb.block_o, bb.key_o, p, k);
    end
    bb.cmd = 2'b11;
    step();
    bb.cmd = 2'b00;
    vecs++;
    if (bb.start_o !== 1'b1) begin
      miss++; $display("FAIL wide_start got %b exp 1", bb.start_o);
    end
    step(); step();
    bb.core_done_i = 1'b1; bb.result_i = r;
    step();
    bb.core_done_i = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (j > 0) step();
      vecs++;
      if (bb.dout_valid !== 1'b1 || bb.dout !== 32'(r >> (96 - 32 * j)) || bb.engine_done !== (j == 0)) begin
        miss++; $display("FAIL wide_beat%0d got dv=%b d=%h exp 1 %h", j, bb.dout_valid, bb.dout, 32'(r >> (96 - 32 * j)));
      end
    end
    step();
    vecs++;
    if (bb.dout_valid !== 1'b0 || bb.key_o !== k) begin
      miss++; $display("FAIL wide_end got dv=%b key=%h exp 0 %h", bb.dout_valid, bb.key_o, k);
    end
  endtask

  initial begin
    test_reset();
    test_spec_vector();
    test_key_retained();
    test_back_to_back();
    test_not_ready();
    test_interleave();
    test_reset_mid_out();
    test_wide();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule

// File: doc/aes_io_ctrl.md
# aes_io_ctrl

Parametrised host-side command front end for the AES datapath. It accepts plaintext and key as a stream of DIN_W-bit beats under a 2-bit command, supports 128/192/256-bit keys, and launches the core with a start/done handshake. It then returns the ciphertext as a serial DIN_W-bit stream. It sits between the byte-wide host port and the AES round core, and generalises the existing 8-bit, 128-bit-key load interface.

## Interface
- DIN_W, 8, beat width; must be 8, 16 or 32.
- KEY_BITS, 128, key length; must be 128, 192 or 256. Elaboration fails if 128 % DIN_W ≠ 0 or KEY_BITS % DIN_W ≠ 0.
- clk  in  1  single clock, rising edge.
- rst_  in  1  synchronous reset, active-low.
- din  in  DIN_W  load beat.
- cmd  in  2  00 idle, 01 set plaintext, 10 set key, 11 start.
- interface_ready  out  1  plaintext and key both complete; controller is idle.
- engine_done  out  1  one-cycle pulse when the result is captured.
- cmd_err  out  1  one-cycle pulse when a command is rejected.
- block_o  out  128  plaintext to the core; stable from start_o until done.
- key_o  out  KEY_BITS  key to the core; stable from start_o until done.
- start_o  out  1  one-cycle core launch pulse.
- core_done_i  in  1  core result valid (single-cycle pulse).
- result_i  in  128  core ciphertext; sampled when core_done_i is high.
- dout  out  DIN_W  ciphertext beat.
- dout_valid  out  1  dout holds a valid beat.

## Operation
- Beat counts:
  - BP = 128/DIN_W beats for plaintext.
  - BK = KEY_BITS/DIN_W beats for the key.
- States: IDLE, START, WAIT, OUT.
- Loading in IDLE, cmd=01:
  - Each cycle shifts din in MSB-first: pt <= {pt[127-DIN_W:0], din}. The first beat lands in bits [127:128-DIN_W] after BP beats.
  - pt_cnt increments and saturates at BP; pt_full is set at BP.
  - Beats arriving while pt_full is set are ignored; no error.
- cmd=10 loads the key identically, using key_cnt, BK and key_full.
- A load sequence restarts (count cleared, full flag cleared, register overwritten) when cmd enters 01 (or 10) and the previous cycle's cmd differed. Interleaving SP and SK therefore restarts the interrupted field.
- interface_ready = (state==IDLE) && pt_full && key_full.
- cmd=11 in IDLE:
  - If ready: go to START. pt_full clears; key_full is retained, so the next block needs only a new plaintext.
  - If not ready: cmd_err pulses and the state stays IDLE. This repeats every cycle while cmd=11 is held.
- START: start_o=1 for exactly one cycle, then WAIT unconditionally. core_done_i in START is ignored.
- WAIT: when core_done_i=1, capture result_i into out_sr and go to OUT.
- OUT:
  - Lasts exactly BP cycles; dout = out_sr[127:128-DIN_W], with a left shift each cycle.
  - After the last beat, return to IDLE.
- Outside IDLE:
  - cmd 01/10 are ignored and pulse cmd_err.
  - cmd 11 is ignored silently.
  - cmd 00 is a no-op.
- block_o and key_o continuously reflect the pt and key registers.
- Reset mid-operation: state goes to IDLE; all counters, flags, registers and outputs clear; any in-flight core result is dropped.

## Timing
- Reset (rst_=0 at an edge): every output is 0, including block_o, key_o and dout.
- Load: a beat sampled at edge n is counted at edge n. interface_ready rises the cycle after the final beat's edge.
- Start latency: cmd=11 sampled at edge n (ready) gives start_o=1 during cycle n+1, and state=WAIT from edge n+1.
- Done: core_done_i sampled at edge m gives the following during cycle m+1:
  - engine_done=1;
  - dout_valid=1 with the first beat.
  
  dout_valid stays high for cycles m+1 .. m+BP. interface_ready can reassert at m+BP+1 at the earliest.
- Turnaround with the key retained: BP plaintext beats + 1 + core latency + BP output cycles.
- cmd_err is registered: asserted the cycle after the offending command is sampled.

## Test plan
- Default parameters:
  - Reset, then 16 beats of cmd=01 with plaintext 00041214120412000C00131108231919.
  - Then 16 beats of cmd=10 with key 2475A2B33475568831E2120013AA5487.
  - Expect: interface_ready=1 after the last key beat; block_o and key_o equal those values.
  - cmd=11 → start_o one pulse.
  - A stub core asserting done 10 cycles later with result_i=0x0123…EF → engine_done one pulse; dout streams 01,23,…,EF over 16 cycles.
- cmd=11 with only 8 key beats loaded → cmd_err pulses each cycle and start_o stays 0.
- Second block with key retained: load a new plaintext only, then cmd=11 → starts; key_o unchanged.
- DIN_W=32, KEY_BITS=256:
  - 4 plaintext beats and 8 key beats → ready.
  - Output is 4 beats, most significant word first.
- Busy rejection: cmd=01 during WAIT → cmd_err pulses and block_o is unchanged.
- rst_=0 during OUT (beat 5) → next cycle dout_valid=0, interface_ready=0, all outputs 0; a full reload is required.
